// File: rtl/vec_mul_feeder_if.sv
// rtl/vec_mul_feeder_if.sv - weight/activation streams and vec_mul_1x64 producer outputs
interface vec_mul_feeder_if #(
  parameter int WEIGHT_BW   = 8,
  parameter int DATA_BW     = 8,
  parameter int MATRIX_SIZE = 8,
  parameter int CNT_BW      = 16
);
  logic                                       w_valid;
  logic                                       w_ready;
  logic [WEIGHT_BW*MATRIX_SIZE-1:0]           w_row;
  logic                                       din_valid;
  logic                                       din_ready;
  logic [DATA_BW*MATRIX_SIZE-1:0]             din;
  logic [WEIGHT_BW*MATRIX_SIZE*MATRIX_SIZE-1:0] weights;
  logic                                       weight_reload;
  logic [DATA_BW*MATRIX_SIZE-1:0]             data_in;
  logic                                       data_in_valid;
  logic                                       loaded;
  logic [CNT_BW-1:0]                          rows_issued;

  // Upstream side: supplies weight beats and activation rows, observes everything else.
  modport master (
    output w_valid, w_row, din_valid, din,
    input  w_ready, din_ready, weights, weight_reload, data_in, data_in_valid, loaded, rows_issued
  );

  // Feeder side.
  modport slave (
    input  w_valid, w_row, din_valid, din,
    output w_ready, din_ready, weights, weight_reload, data_in, data_in_valid, loaded, rows_issued
  );
endinterface

// File: rtl/vec_mul_feeder.sv
// rtl/vec_mul_feeder.sv - double-buffered weight loader and activation row register
module vec_mul_feeder #(
  parameter int WEIGHT_BW   = 8,
  parameter int DATA_BW     = 8,
  parameter int MATRIX_SIZE = 8,
  parameter int CNT_BW      = 16
) (
  input logic            clk,
  input logic            rst,
  vec_mul_feeder_if.slave bus
);
  localparam int ROW_W  = WEIGHT_BW * MATRIX_SIZE;
  localparam int BANK_W = ROW_W * MATRIX_SIZE;
  localparam int FCW    = $clog2(MATRIX_SIZE + 1);
  localparam logic [FCW-1:0]    LAST_BEAT = FCW'(MATRIX_SIZE - 1);
  localparam logic [CNT_BW-1:0] CNT_MAX   = {CNT_BW{1'b1}};

  // S_SWAP is exactly the single cycle where fill_cnt == MATRIX_SIZE.
  typedef enum logic {S_FILL, S_SWAP} state_t;

  state_t            state;
  logic [FCW-1:0]    fill_cnt;
  logic [BANK_W-1:0] shadow;
  logic              w_hs;
  logic              din_hs;

  // Both streams stall during the swap cycle; activations also wait for the first bank.
  assign bus.w_ready   = (state == S_FILL);
  assign bus.din_ready = bus.loaded && (state == S_FILL);
  assign w_hs          = bus.w_valid && bus.w_ready;
  assign din_hs        = bus.din_valid && bus.din_ready;

  // Shadow fill, bank swap, activation register and issue counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_FILL;
      fill_cnt          <= '0;
      shadow            <= '0;
      bus.weights       <= '0;
      bus.weight_reload <= 1'b0;
      bus.data_in       <= '0;
      bus.data_in_valid <= 1'b0;
      bus.loaded        <= 1'b0;
      bus.rows_issued   <= '0;
    end else begin
      bus.weight_reload <= 1'b0;
      bus.data_in_valid <= din_hs;
      if (din_hs) begin
        bus.data_in <= bus.din;
        if (bus.rows_issued != CNT_MAX) begin
          bus.rows_issued <= bus.rows_issued + CNT_BW'(1);
        end
      end

      if (w_hs) begin
        for (int r = 0; r < MATRIX_SIZE; r++) begin
          if (fill_cnt == FCW'(r)) begin
            shadow[r*ROW_W +: ROW_W] <= bus.w_row;
          end
        end
        fill_cnt <= fill_cnt + FCW'(1);
        if (fill_cnt == LAST_BEAT) begin
          state <= S_SWAP;
        end
      end

      // Rows accepted up to the last beat were issued against the old bank; swap now.
      if (state == S_SWAP) begin
        bus.weights       <= shadow;
        bus.weight_reload <= 1'b1;
        bus.loaded        <= 1'b1;
        bus.rows_issued   <= '0;
        fill_cnt          <= '0;
        state             <= S_FILL;
      end
    end
  end
endmodule

// File: tb/tb_vec_mul_feeder.sv
// tb/tb_vec_mul_feeder.sv - directed self-checking bench for vec_mul_feeder
module tb_vec_mul_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  vec_mul_feeder_if b ();
  vec_mul_feeder_if #(.CNT_BW(4)) b4 ();

  vec_mul_feeder u_dut (.clk(clk), .rst(rst), .bus(b.slave));
  vec_mul_feeder #(.CNT_BW(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk_row(input logic [7:0] base);
    logic [63:0] r;
    for (int c = 0; c < 8; c++) r[c*8 +: 8] = 8'(base + c);
    return r;
  endfunction

  function automatic logic [511:0] mk_bank(input logic [7:0] base);
    logic [511:0] k;
    for (int i = 0; i < 64; i++) k[i*8 +: 8] = 8'(base + i);
    return k;
  endfunction

  function automatic logic [63:0] drow(input int i);
    return 64'h0102030405060708 + 64'(i);
  endfunction

  initial begin
    logic [511:0] bank1;
    logic [511:0] bank2;
    bank1 = mk_bank(8'h01);
    bank2 = mk_bank(8'h80);
    b.w_valid = 0; b.w_row = '0; b.din_valid = 0; b.din = '0;
    b4.w_valid = 0; b4.w_row = '0; b4.din_valid = 0; b4.din = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_weights", b.weights, '0);
    check("rst_reload", b.weight_reload, 0);
    check("rst_data_in", b.data_in, '0);
    check("rst_dv", b.data_in_valid, 0);
    check("rst_loaded", b.loaded, 0);
    check("rst_rows", b.rows_issued, 0);
    check("rst_w_ready", b.w_ready, 1);

    // Activations refused before any bank is loaded
    b.din_valid = 1; b.din = drow(0);
    check("preload_din_ready", b.din_ready, 0);
    tick();
    check("preload_dv", b.data_in_valid, 0);
    b.din_valid = 0;

    // First load: 8 beats, weights byte k = k+1
    for (int r = 0; r < 8; r++) begin
      b.w_valid = 1; b.w_row = mk_row(8'(1 + r*8));
      tick();
    end
    b.w_valid = 0;
    check("swap1_w_ready", b.w_ready, 0);
    check("swap1_din_ready", b.din_ready, 0);
    check("swap1_reload", b.weight_reload, 0);
    check("swap1_weights_old", b.weights, '0);
    tick();
    check("load1_weights", b.weights, bank1);
    check("load1_reload", b.weight_reload, 1);
    check("load1_loaded", b.loaded, 1);
    check("load1_w_ready", b.w_ready, 1);
    check("load1_din_ready", b.din_ready, 1);
    tick();
    check("load1_reload_drop", b.weight_reload, 0);

    // Five back-to-back activation rows
    for (int i = 0; i < 5; i++) begin
      b.din_valid = 1; b.din = drow(i);
      tick();
      check("stream_dv", b.data_in_valid, 1);
      check("stream_data", b.data_in, drow(i));
    end
    b.din_valid = 0;
    check("stream_rows5", b.rows_issued, 5);
    tick();
    check("idle_dv", b.data_in_valid, 0);
    check("idle_hold", b.data_in, drow(4));

    // Second load interleaved with continuous activations
    b.din_valid = 1;
    for (int r = 0; r < 8; r++) begin
      b.w_valid = 1; b.w_row = mk_row(8'(8'h80 + r*8)); b.din = drow(5 + r);
      tick();
      check("ovl_dv", b.data_in_valid, 1);
      check("ovl_data", b.data_in, drow(5 + r));
      check("ovl_weights_old", b.weights, bank1);
      check("ovl_reload", b.weight_reload, 0);
    end
    b.w_valid = 0; b.din = drow(13);
    check("swap2_din_ready", b.din_ready, 0);
    check("swap2_w_ready", b.w_ready, 0);
    check("swap2_rows13", b.rows_issued, 13);
    check("swap2_weights_old", b.weights, bank1);
    tick();
    check("load2_weights", b.weights, bank2);
    check("load2_reload", b.weight_reload, 1);
    check("load2_dv_zero", b.data_in_valid, 0);
    check("load2_rows0", b.rows_issued, 0);
    check("load2_din_ready", b.din_ready, 1);
    tick();
    check("post2_dv", b.data_in_valid, 1);
    check("post2_data", b.data_in, drow(13));
    check("post2_rows1", b.rows_issued, 1);
    check("post2_reload_drop", b.weight_reload, 0);
    b.din_valid = 0;
    tick();

    // Reset after 3 of 8 beats
    for (int r = 0; r < 3; r++) begin
      b.w_valid = 1; b.w_row = mk_row(8'(8'hC0 + r*8));
      tick();
    end
    b.w_valid = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_weights", b.weights, '0);
    check("mid_rst_loaded", b.loaded, 0);
    check("mid_rst_rows", b.rows_issued, 0);
    check("mid_rst_data_in", b.data_in, '0);
    check("mid_rst_din_ready", b.din_ready, 0);
    for (int r = 0; r < 8; r++) begin
      b.w_valid = 1; b.w_row = mk_row(8'(1 + r*8));
      tick();
    end
    b.w_valid = 0;
    check("reload_swap_w_ready", b.w_ready, 0);
    tick();
    check("reload_clean_bank", b.weights, bank1);
    check("reload_pulse", b.weight_reload, 1);

    // Saturation with a 4-bit counter
    for (int r = 0; r < 8; r++) begin
      b4.w_valid = 1; b4.w_row = mk_row(8'(1 + r*8));
      tick();
    end
    b4.w_valid = 0;
    tick();
    check("sat_loaded", b4.loaded, 1);
    b4.din_valid = 1;
    for (int i = 1; i <= 20; i++) begin
      b4.din = drow(i);
      tick();
      if (i == 14) check("sat_rows14", b4.rows_issued, 14);
    end
    b4.din_valid = 0;
    check("sat_rows15", b4.rows_issued, 15);
    check("sat_last_data", b4.data_in, drow(20));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
